// File: rtl/vcve2_pkg.sv
// Shared constants and types for the VRF read-side sequencer.
// Derived sizes come from helper functions so that a top instantiated with
// non-default VLEN/MAX_LMUL computes its own widths consistently.
package vcve2_pkg;

  localparam int DEF_VLEN       = 128;
  localparam int DEF_MAX_LMUL   = 8;
  localparam int DEF_FIFO_DEPTH = 2;

  // Words per vector register.
  function automatic int calc_wpr(input int vlen);
    return vlen / 32;
  endfunction

  // Word-address width covering all 32 registers.
  function automatic int calc_vrf_aw(input int vlen);
    return $clog2(32 * (vlen / 32));
  endfunction

  // Request length width; +1 so the full group length itself is representable.
  function automatic int calc_nw_w(input int vlen, input int max_lmul);
    return $clog2((vlen / 32) * max_lmul) + 1;
  endfunction

  localparam int WPR    = calc_wpr(DEF_VLEN);
  localparam int VRF_AW = calc_vrf_aw(DEF_VLEN);
  localparam int NW_W   = calc_nw_w(DEF_VLEN, DEF_MAX_LMUL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/vcve2_vrf_rd_fifo.sv
// Small output buffer for returned VRF words: any depth >= 2, same-cycle
// push/pop, synchronous clear. Storage is reset so the head reads 0 when empty
// after reset.
module vcve2_vrf_rd_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 33,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/vcve2_vrf_rd_seq.sv
// VRF read-side sequencer: takes one operand-fetch request (base vreg + word
// count), issues word reads on the 1-cycle-latency read port, buffers the
// returned words and streams them to the execute unit.
// Optional build macro VCVE2_VRF_RD_FWD_EN: a read issued in the same cycle as
// a writeback write to the same word captures the writeback data instead.
//
// Handshakes: a request is accepted on a cycle where req_valid_i and
// req_ready_o are both 1; an operand beat transfers on a cycle where
// op_valid_o and op_ready_i are both 1, and op_valid_o/op_data_o/op_last_o hold
// steady while op_valid_o=1 and op_ready_i=0.
module vcve2_vrf_rd_seq
  import vcve2_pkg::*;
#(
  parameter int VLEN       = DEF_VLEN,
  parameter int MAX_LMUL   = DEF_MAX_LMUL,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [4:0]                           req_vreg_i,
  input  logic [calc_nw_w(VLEN, MAX_LMUL)-1:0] req_nwords_i,
  output logic                                 vrf_re_o,
  output logic [calc_vrf_aw(VLEN)-1:0]         vrf_raddr_o,
  input  logic [31:0]                          vrf_rdata_i,
  input  logic                                 vrf_we_wb_i,
  input  logic [calc_vrf_aw(VLEN)-1:0]         vrf_waddr_wb_i,
  input  logic [31:0]                          vrf_wdata_wb_i,
  output logic                                 op_valid_o,
  input  logic                                 op_ready_i,
  output logic [31:0]                          op_data_o,
  output logic                                 op_last_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int WPR_L = calc_wpr(VLEN);
  localparam int AW_L  = calc_vrf_aw(VLEN);
  localparam int NWW_L = calc_nw_w(VLEN, MAX_LMUL);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  state_e            state_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              done_q;
  logic [AW_L-1:0]   base_q;
  logic [NWW_L-1:0]  nwords_q;
  logic [NWW_L-1:0]  issue_q;
  logic [NWW_L-1:0]  push_idx_q;
  logic              pending_q;

  logic [AW_L-1:0]   req_base;
  logic [AW_L-1:0]   raddr;
  logic [CW:0]       occ;
  logic              space;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic              push;
  logic              push_last;
  logic [31:0]       push_word;
  logic [32:0]       fifo_head;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;

  assign req_base   = AW_L'(req_vreg_i) * AW_L'(WPR_L);
  // Address arithmetic is modulo the VRF size, so a group past v31 wraps to v0.
  assign raddr      = base_q + AW_L'(issue_q);
  assign pop        = ~fifo_empty & op_ready_i;
  // Entries already buffered plus the one in flight, less the one leaving now,
  // must leave room for the word this read will return.
  assign occ        = {1'b0, fifo_cnt} + {{CW{1'b0}}, pending_q};
  assign space      = occ < ((CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop});
  assign issue      = (state_q == READ) & space & ~flush_i;
  assign last_issue = (issue_q == nwords_q - NWW_L'(1));
  assign push       = pending_q & ~flush_i;
  assign push_last  = (push_idx_q == nwords_q - NWW_L'(1));

  assign req_ready_o = req_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign vrf_re_o    = issue;
  assign vrf_raddr_o = issue ? raddr : '0;
  assign op_valid_o  = ~fifo_empty;
  assign op_data_o   = fifo_head[31:0];
  assign op_last_o   = fifo_head[32];

`ifdef VCVE2_VRF_RD_FWD_EN
  logic        fwd_hit_q;
  logic [31:0] fwd_data_q;

  // Remember a same-cycle writeback to the word being read; the RAM returns the
  // pre-write value, so the writeback data replaces it on return.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= issue & vrf_we_wb_i & (vrf_waddr_wb_i == raddr);
      fwd_data_q <= vrf_wdata_wb_i;
    end
  end

  assign push_word = fwd_hit_q ? fwd_data_q : vrf_rdata_i;
`else
  // Writeback hazards are resolved upstream; the write-port copy is not needed.
  logic unused_wb;
  assign unused_wb = ^{vrf_we_wb_i, vrf_waddr_wb_i, vrf_wdata_wb_i};
  assign push_word = vrf_rdata_i;
`endif

  // Control FSM with registered ready/busy/done; flush overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      base_q      <= '0;
      nwords_q    <= '0;
      issue_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q     <= IDLE;
        req_ready_q <= 1'b1;
        busy_q      <= 1'b0;
        base_q      <= '0;
        nwords_q    <= '0;
        issue_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid_i) begin
              base_q   <= req_base;
              nwords_q <= req_nwords_i;
              issue_q  <= '0;
              if (req_nwords_i == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q     <= READ;
                req_ready_q <= 1'b0;
                busy_q      <= 1'b1;
              end
            end
          end
          READ: begin
            if (issue) begin
              issue_q <= issue_q + NWW_L'(1);
              if (last_issue) state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (!pending_q && fifo_empty) begin
              done_q      <= 1'b1;
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
          default: begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  // In-flight read flag and index of the next word to land in the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= 1'b0;
      push_idx_q <= '0;
    end else if (flush_i) begin
      pending_q  <= 1'b0;
      push_idx_q <= '0;
    end else begin
      pending_q <= issue;
      if (state_q == IDLE && req_valid_i) push_idx_q <= '0;
      else if (push)                      push_idx_q <= push_idx_q + NWW_L'(1);
    end
  end

  vcve2_vrf_rd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(33)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .push_i (push),
    .data_i ({push_last, push_word}),
    .pop_i  (pop),
    .data_o (fifo_head),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

endmodule

// File: tb/tb_vcve2_vrf_rd_seq.sv
// Bench for the VRF read sequencer: table of directed requests, hand-written
// zero-length / flush / reset / forwarding sequences, then random requests.
// Expected beats and addresses come from a word-level model of the register
// file (group = consecutive words from vreg*WPR, modulo the VRF size).
module tb_vcve2_vrf_rd_seq;
  import vcve2_pkg::*;

  localparam int AW     = VRF_AW;
  localparam int NWW    = NW_W;
  localparam int DEPTH  = DEF_FIFO_DEPTH;
  localparam int NWORDS = 32 * WPR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic           flush = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [4:0]     req_vreg = '0;
  logic [NWW-1:0] req_nwords = '0;
  logic           vrf_re;
  logic [AW-1:0]  vrf_raddr;
  logic [31:0]    vrf_rdata = '0;
  logic           vrf_we = 1'b0;
  logic [AW-1:0]  vrf_waddr = AW'(17);
  logic [31:0]    vrf_wdata = 32'hDEADBEEF;
  logic           op_valid;
  logic           op_ready = 1'b0;
  logic [31:0]    op_data;
  logic           op_last;
  logic           busy;
  logic           done;

  vcve2_vrf_rd_seq dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_vreg_i    (req_vreg),
    .req_nwords_i  (req_nwords),
    .vrf_re_o      (vrf_re),
    .vrf_raddr_o   (vrf_raddr),
    .vrf_rdata_i   (vrf_rdata),
    .vrf_we_wb_i   (vrf_we),
    .vrf_waddr_wb_i(vrf_waddr),
    .vrf_wdata_wb_i(vrf_wdata),
    .op_valid_o    (op_valid),
    .op_ready_i    (op_ready),
    .op_data_o     (op_data),
    .op_last_o     (op_last),
    .busy_o        (busy),
    .done_o        (done)
  );

  // VRF model: synchronous read returning the pre-write value, writeback port.
  logic [31:0] mem [NWORDS];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= $urandom;
    end else begin
      if (vrf_re) vrf_rdata <= mem[vrf_raddr];
      if (vrf_we) mem[vrf_waddr] <= vrf_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [32:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int addr_log[$];
  int beat_log[$];
  int done_cnt = 0;
  int done_cyc = -1;
  int out_cnt = 0;
  int ovf = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_head = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    chk_cnt++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  task automatic build_exp(input int vreg, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = (vreg * WPR + i) % NWORDS;
      exp_addr_q.push_back(AW'(a));
      exp_q.push_back({(i == n - 1), mem[a]});
    end
  endtask

  // Monitor sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      out_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", 64'({op_valid, op_last, op_data}), 64'({1'b1, prev_head}));
      prev_stall = op_valid && !op_ready;
      prev_head  = {op_last, op_data};
      if (vrf_re) begin
        addr_log.push_back(int'(vrf_raddr));
        if (exp_addr_q.size() == 0) fail_now("read_unexpected", 64'(vrf_raddr));
        else chk("raddr", 64'(vrf_raddr), 64'(exp_addr_q.pop_front()));
      end
      if (op_valid && op_ready) begin
        beat_log.push_back(cyc);
        if (exp_q.size() == 0) fail_now("beat_unexpected", 64'({op_last, op_data}));
        else chk("beat", 64'({op_last, op_data}), 64'(exp_q.pop_front()));
      end
      out_cnt = out_cnt + int'(vrf_re) - int'(op_valid && op_ready);
      if (out_cnt > DEPTH + 1) ovf++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int k = 0;
    while (!req_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) fail_now("idle_timeout", 64'(busy));
  endtask

  // mode 0: ready held 1; 1: random ready; 2: ready low 5 cycles after 2 beats.
  task automatic run_req(input int vreg, input int n, input int mode, input bit inject,
                         output int acc_cyc, output int r0, output int b0);
    int d0, cnt, stall;
    bit injected;
    cnt = 0; stall = 0; injected = 1'b0;
    wait_idle();
    r0 = addr_log.size();
    b0 = beat_log.size();
    d0 = done_cnt;
    build_exp(vreg, n);
    if (inject) begin
`ifdef VCVE2_VRF_RD_FWD_EN
      exp_q[1] = {1'b0, 32'hDEADBEEF};
`endif
    end
    req_vreg   = 5'(vreg);
    req_nwords = NWW'(n);
    req_valid  = 1'b1;
    op_ready   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    while (done_cnt == d0 && cnt < 800) begin
      case (mode)
        0: op_ready = 1'b1;
        1: op_ready = 1'($urandom_range(0, 1));
        default: begin
          if (beat_log.size() - b0 >= 2 && stall < 5) begin
            op_ready = 1'b0;
            stall++;
          end else begin
            op_ready = 1'b1;
          end
        end
      endcase
      #1;
      vrf_we = inject && !injected && vrf_re && (vrf_raddr == AW'(17));
      if (vrf_we) injected = 1'b1;
      @(posedge clk); #1;
      cnt++;
    end
    vrf_we   = 1'b0;
    op_ready = 1'b0;
    chk("req_no_timeout", 64'(cnt < 800), 64'(1));
    chk("beat_count", 64'(beat_log.size() - b0), 64'(n));
    chk("read_count", 64'(addr_log.size() - r0), 64'(n));
    chk("exp_drained", 64'(exp_q.size()), 64'(0));
    if (inject) chk("fwd_same_cycle", 64'(injected), 64'(1));
  endtask

  typedef struct {
    int vreg;
    int n;
    int mode;
    int first_addr;
    int last_addr;
  } vec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[7];
    int   acc, r0, b0, d0, k, vr, nw, md;
    bit   seen;

    tbl[0] = '{4,  8,  0, 16,  23};
    tbl[1] = '{30, 12, 0, 120, 3};
    tbl[2] = '{30, 12, 2, 120, 3};
    tbl[3] = '{0,  1,  0, 0,   0};
    tbl[4] = '{31, 4,  1, 124, 127};
    tbl[5] = '{10, 32, 2, 40,  71};
    tbl[6] = '{5,  3,  2, 20,  22};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_op_valid", 64'(op_valid), 64'(0));
    chk("rst_op_data", 64'({op_last, op_data}), 64'(0));
    chk("rst_vrf_re", 64'({vrf_re, vrf_raddr}), 64'(0));

    // Zero-length request
    @(posedge clk); #1;
    d0 = done_cnt;
    b0 = beat_log.size();
    req_vreg = 5'd3; req_nwords = '0; req_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("zero_done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("zero_done_cycle", 64'(done_cyc - acc), 64'(0));
    chk("zero_no_beats", 64'(beat_log.size() - b0), 64'(0));
    chk("zero_ready", 64'(req_ready), 64'(1));

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_req(tbl[i].vreg, tbl[i].n, tbl[i].mode, 1'b0, acc, r0, b0);
      chk("tbl_first_addr", 64'(addr_log[r0]), 64'(tbl[i].first_addr));
      chk("tbl_last_addr", 64'(addr_log[r0 + tbl[i].n - 1]), 64'(tbl[i].last_addr));
      if (tbl[i].mode == 0) begin
        chk("first_beat_latency", 64'(beat_log[b0] - acc), 64'(2));
        chk("back_to_back", 64'(beat_log[b0 + tbl[i].n - 1] - beat_log[b0]), 64'(tbl[i].n - 1));
        chk("done_after_last", 64'(done_cyc - beat_log[b0 + tbl[i].n - 1]), 64'(2));
      end
    end

    // Flush with a read in flight after beat 3 of 8
    wait_idle();
    d0 = done_cnt;
    b0 = beat_log.size();
    build_exp(8, 8);
    req_vreg = 5'd8; req_nwords = NWW'(8); req_valid = 1'b1; op_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (beat_log.size() - b0 < 3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("flush_setup", 64'(beat_log.size() - b0), 64'(3));
    flush = 1'b1;
    op_ready = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", 64'(req_ready), 64'(1));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_op_valid", 64'(op_valid), 64'(0));
    seen = 1'b0;
    op_ready = 1'b1;
    repeat (6) begin
      if (op_valid || vrf_re) seen = 1'b1;
      @(posedge clk); #1;
    end
    op_ready = 1'b0;
    chk("flush_quiet", 64'(seen), 64'(0));
    chk("flush_no_done", 64'(done_cnt - d0), 64'(0));
    run_req(8, 8, 0, 1'b0, acc, r0, b0);

    // Reset in the middle of a request
    wait_idle();
    build_exp(2, 16);
    req_vreg = 5'd2; req_nwords = NWW'(16); req_valid = 1'b1; op_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_outputs", 64'({op_valid, vrf_re, done}), 64'(0));
    exp_q.delete();
    exp_addr_q.delete();
    op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Read of word 17 coinciding with a writeback to it
    run_req(4, 8, 0, 1'b1, acc, r0, b0);

    // Random requests against the model
    for (int i = 0; i < 20; i++) begin
      vr = $urandom_range(0, 31);
      nw = $urandom_range(0, WPR * DEF_MAX_LMUL);
      md = $urandom_range(0, 2);
      run_req(vr, nw, md, 1'b0, acc, r0, b0);
    end

    chk("outstanding_bound", 64'(ovf), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
